frame_sync_ctrl: RTL and testbench
==================================

# frame_sync_ctrl

Frame-alignment controller that sequences the line datapath. Locks onto the frame alignment signal (FAS) in the incoming byte stream. Generates the row/column counters consumed by the CRC calculator and downstream map/demap stages, and gates the data-valid strobe until alignment is found. Sits between the line receiver and the CRC calculator; also accumulates CRC errors reported back by the demap-mode CRC calculator.

## Interface
- ROWS, 4, rows per frame (row counter 0..ROWS-1)
- COLS, 1041, columns per row (column counter 0..COLS-1; cols 0-15 overhead, 16-1039 payload, 1040 CRC slot on row 3)
- SYNC_FRAMES, 2, consecutive correct FAS needed to declare in-frame
- LOSS_FRAMES, 3, consecutive missing FAS needed to declare loss of frame
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_frame_data  in  8  line byte
- i_frame_data_valid  in  1  byte qualifier
- i_frame_data_fas  in  1  FAS marker; meaningful only with valid
- i_crc_err  in  1  CRC error level from the CRC calculator
- i_cnt_clr  in  1  synchronous clear of the error counter
- o_frame_data  out  8  registered data
- o_frame_data_valid  out  1  registered valid, gated by alignment state
- o_frame_data_fas  out  1  registered FAS
- o_row_cnt  out  2  row of the byte on o_frame_data
- o_col_cnt  out  11  column of the byte on o_frame_data
- o_in_frame  out  1  high in IF and PRE_OOF
- o_lof  out  1  one-cycle pulse on transition into OOF from PRE_OOF
- o_crc_err_cnt  out  16  saturating CRC error count

## Operation
- Position counters (col, row) advance only on input valid beats. Col wraps COLS-1 -> 0 and increments row; row wraps ROWS-1 -> 0. The expected FAS position is the beat that maps to row 0 col 0.
- States: OOF, PRE_IF, IF, PRE_OOF. Reset state is OOF.
- OOF: a valid beat with FAS loads the counters so that beat is row 0 col 0. Go to PRE_IF with hit count = 1. Valid beats without FAS are ignored. Counters hold 0.
- PRE_IF: at each expected-position beat, FAS present increments the hit count; reaching SYNC_FRAMES goes to IF. FAS absent at the expected position goes to OOF.
- IF: FAS absent at the expected position goes to PRE_OOF with miss count = 1.
- PRE_OOF: FAS present at the expected position goes back to IF and clears the miss count. FAS absent increments the miss count; reaching LOSS_FRAMES goes to OOF and pulses o_lof.
- FAS on a non-expected beat is ignored in PRE_IF, IF and PRE_OOF; there is no realignment without passing through OOF.
- o_frame_data_valid = input valid AND state != OOF. The FAS beat that causes OOF->PRE_IF is output valid. Data and FAS pass through regardless of state.
- CRC error counter increments on each rising edge of i_crc_err while o_in_frame. It saturates at 16'hFFFF.
- i_cnt_clr coincident with an increment: clear wins, and the result is 0.

## Timing
- Reset values: every output is 0, the counters are 0, and the state is OOF.
- Latency is one cycle from input to output. o_row_cnt/o_col_cnt are registered with, and describe, the byte on o_frame_data.
- State transitions take effect on the same edge that registers the deciding beat. o_in_frame and o_lof are aligned with that beat's output.
- Invalid input cycles: the counters and state hold, and o_frame_data_valid = 0.
- Reset asserted mid-frame clears everything asynchronously. After release, the block re-enters OOF and needs a fresh FAS.

## Structure
- Shared package: frame geometry constants (ROWS, COLS, overhead end 15, payload end 1039, CRC column 1040), the state encoding typedef, and counter widths. These are shared with the CRC calculator and the map/demap blocks.
- One natural sub-module: frame_pos_cnt, the row/column counter with load-to-origin and advance-on-valid.

## Test plan
- Reset then 3 clean frames with FAS every 4164 valid beats -> PRE_IF at beat 0. o_in_frame rises on the second frame's FAS beat. Counters read row 3 col 1040 on the last beat of each frame.
- Valid gaps (valid low 1 of every 3 cycles) -> counters hold during gaps and frame timing is unchanged; lock is the same as the clean case.
- In lock, drop FAS for 2 frames then restore -> IF->PRE_OOF->PRE_OOF->IF. No o_lof pulse and o_in_frame stays high. Drop 3 frames -> single o_lof pulse, OOF, valid gated to 0.
- In PRE_IF, spurious FAS at row 1 col 500 and a missing expected FAS -> spurious FAS ignored. The missing FAS returns the block to OOF.
- i_crc_err pulsed on 5 frames in lock plus 2 in OOF -> o_crc_err_cnt = 5. i_cnt_clr coincident with a 6th pulse -> 0.
- Force the counter to 16'hFFFE, then 3 error pulses -> the counter holds at 16'hFFFF. Assert i_rst_n low mid-frame -> all outputs are 0 asynchronously.

Source files
------------

// File: rtl/frame_sync_pkg.sv
// Frame geometry, state encoding and counter widths shared by the line datapath blocks.
package frame_sync_pkg;

  localparam int FRAME_ROWS      = 4;
  localparam int FRAME_COLS      = 1041;
  localparam int OH_END_COL      = 15;
  localparam int PAYLOAD_END_COL = 1039;
  localparam int CRC_COL         = 1040;

  localparam int ROW_W = 2;
  localparam int COL_W = 11;
  localparam int ERR_W = 16;

  typedef enum logic [1:0] {
    ST_OOF     = 2'd0,
    ST_PRE_IF  = 2'd1,
    ST_IF      = 2'd2,
    ST_PRE_OOF = 2'd3
  } fs_state_t;

endpackage

// File: rtl/frame_pos_cnt.sv
// Row/column position counter. Holds the position that the next valid beat will occupy.
module frame_pos_cnt
  import frame_sync_pkg::*;
#(
  parameter int ROWS = FRAME_ROWS,
  parameter int COLS = FRAME_COLS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             adv,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  // Clear to origin, load so the loading beat sits at row 0 col 0, or advance one column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (load) begin
      row <= '0;
      col <= COL_W'(1);
    end else if (adv) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame-alignment controller: FAS lock FSM, position counters, gated valid and CRC error count.
module frame_sync_ctrl
  import frame_sync_pkg::*;
#(
  parameter int ROWS        = FRAME_ROWS,
  parameter int COLS        = FRAME_COLS,
  parameter int SYNC_FRAMES = 2,
  parameter int LOSS_FRAMES = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [7:0]       i_frame_data,
  input  logic             i_frame_data_valid,
  input  logic             i_frame_data_fas,
  input  logic             i_crc_err,
  input  logic             i_cnt_clr,
  output logic [7:0]       o_frame_data,
  output logic             o_frame_data_valid,
  output logic             o_frame_data_fas,
  output logic [ROW_W-1:0] o_row_cnt,
  output logic [COL_W-1:0] o_col_cnt,
  output logic             o_in_frame,
  output logic             o_lof,
  output logic [ERR_W-1:0] o_crc_err_cnt
);

  fs_state_t        state;
  logic [7:0]       hit_cnt;
  logic [7:0]       miss_cnt;
  logic [ROW_W-1:0] pos_row;
  logic [COL_W-1:0] pos_col;
  logic             beat, at_origin, hit_done, miss_done;
  logic             drop_lock, next_oof, pos_clr, pos_load, pos_adv;

  logic [7:0]       data_p1;
  logic             vld_p1, fas_p1, in_frame_p1, lof_p1;
  logic [ROW_W-1:0] row_p1;
  logic [COL_W-1:0] col_p1;
  logic             crc_err_d;
  logic [ERR_W-1:0] err_cnt;

  // Decisions taken by the current input beat; shared by the FSM and the position counter
  always_comb begin
    beat      = i_frame_data_valid;
    at_origin = (pos_row == '0) && (pos_col == '0);
    hit_done  = (int'(hit_cnt) + 1) >= SYNC_FRAMES;
    miss_done = (int'(miss_cnt) + 1) >= LOSS_FRAMES;
    drop_lock = beat && at_origin && !i_frame_data_fas &&
                ((state == ST_PRE_IF) || ((state == ST_PRE_OOF) && miss_done));
    next_oof  = ((state == ST_OOF) && !(beat && i_frame_data_fas)) || drop_lock;
    pos_load  = beat && (state == ST_OOF) && i_frame_data_fas;
    pos_clr   = (beat && (state == ST_OOF) && !i_frame_data_fas) || drop_lock;
    pos_adv   = beat && (state != ST_OOF) && !drop_lock;
  end

  frame_pos_cnt #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_pos (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clr   (pos_clr),
    .load  (pos_load),
    .adv   (pos_adv),
    .row   (pos_row),
    .col   (pos_col)
  );

  // Alignment FSM with registered in-frame, loss pulse and gated valid
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_OOF;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      vld_p1      <= 1'b0;
      in_frame_p1 <= 1'b0;
      lof_p1      <= 1'b0;
    end else begin
      lof_p1 <= 1'b0;
      vld_p1 <= i_frame_data_valid && !next_oof;
      if (beat) begin
        unique case (state)
          ST_OOF: begin
            if (i_frame_data_fas) begin
              hit_cnt <= 8'd1;
              if (SYNC_FRAMES <= 1) begin
                state       <= ST_IF;
                in_frame_p1 <= 1'b1;
              end else begin
                state <= ST_PRE_IF;
              end
            end
          end
          ST_PRE_IF: begin
            if (at_origin) begin
              if (i_frame_data_fas) begin
                hit_cnt <= hit_cnt + 8'd1;
                if (hit_done) begin
                  state       <= ST_IF;
                  in_frame_p1 <= 1'b1;
                end
              end else begin
                state <= ST_OOF;
              end
            end
          end
          ST_IF: begin
            if (at_origin && !i_frame_data_fas) begin
              miss_cnt <= 8'd1;
              state    <= ST_PRE_OOF;
            end
          end
          ST_PRE_OOF: begin
            if (at_origin) begin
              if (i_frame_data_fas) begin
                miss_cnt <= '0;
                state    <= ST_IF;
              end else if (miss_done) begin
                miss_cnt    <= '0;
                state       <= ST_OOF;
                in_frame_p1 <= 1'b0;
                lof_p1      <= 1'b1;
              end else begin
                miss_cnt <= miss_cnt + 8'd1;
              end
            end
          end
          default: state <= ST_OOF;
        endcase
      end
    end
  end

  // Output stage: data, FAS and the position of that byte
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_p1 <= '0;
      fas_p1  <= 1'b0;
      row_p1  <= '0;
      col_p1  <= '0;
    end else begin
      data_p1 <= i_frame_data;
      fas_p1  <= i_frame_data_fas;
      row_p1  <= pos_row;
      col_p1  <= pos_col;
    end
  end

  // Saturating count of CRC error rising edges while in frame; clear has priority
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_err_d <= 1'b0;
      err_cnt   <= '0;
    end else begin
      crc_err_d <= i_crc_err;
      if (i_cnt_clr) begin
        err_cnt <= '0;
      end else if (i_crc_err && !crc_err_d && in_frame_p1 && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign o_frame_data       = data_p1;
  assign o_frame_data_valid = vld_p1;
  assign o_frame_data_fas   = fas_p1;
  assign o_row_cnt          = row_p1;
  assign o_col_cnt          = col_p1;
  assign o_in_frame         = in_frame_p1;
  assign o_lof              = lof_p1;
  assign o_crc_err_cnt      = err_cnt;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed bench for frame_sync_ctrl: vector table for acquisition, frame tasks for lock/loss/CRC.
module tb_frame_sync_ctrl;

  localparam int COLS        = 1041;
  localparam int FRAME_BEATS = 4164;

  logic        clk;
  logic        rst_n;
  logic [7:0]  i_frame_data;
  logic        i_frame_data_valid;
  logic        i_frame_data_fas;
  logic        i_crc_err;
  logic        i_cnt_clr;
  logic [7:0]  o_frame_data;
  logic        o_frame_data_valid;
  logic        o_frame_data_fas;
  logic [1:0]  o_row_cnt;
  logic [10:0] o_col_cnt;
  logic        o_in_frame;
  logic        o_lof;
  logic [15:0] o_crc_err_cnt;

  int checks;
  int failures;

  int         f_v0, f_if0, f_lof, f_pos_bad, f_gap_bad;
  logic [1:0]  f_last_row;
  logic [10:0] f_last_col;

  frame_sync_ctrl dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_frame_data       (i_frame_data),
    .i_frame_data_valid (i_frame_data_valid),
    .i_frame_data_fas   (i_frame_data_fas),
    .i_crc_err          (i_crc_err),
    .i_cnt_clr          (i_cnt_clr),
    .o_frame_data       (o_frame_data),
    .o_frame_data_valid (o_frame_data_valid),
    .o_frame_data_fas   (o_frame_data_fas),
    .o_row_cnt          (o_row_cnt),
    .o_col_cnt          (o_col_cnt),
    .o_in_frame         (o_in_frame),
    .o_lof              (o_lof),
    .o_crc_err_cnt      (o_crc_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        f;
    logic [7:0]  d;
    logic        e_vld;
    logic        e_fas;
    logic [1:0]  e_row;
    logic [10:0] e_col;
    logic        e_inf;
    logic        chk_pos;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One clock: inputs change just after the edge, outputs are read 1ns after the next edge
  task automatic drive(input logic v, input logic f, input logic [7:0] d,
                       input logic ce, input logic clr);
    i_frame_data_valid = v;
    i_frame_data_fas   = f;
    i_frame_data       = d;
    i_crc_err          = ce;
    i_cnt_clr          = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_frame_data_valid = 1'b0;
    i_frame_data_fas   = 1'b0;
    i_frame_data       = 8'h00;
    i_crc_err          = 1'b0;
    i_cnt_clr          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {o_frame_data, o_frame_data_valid, o_frame_data_fas, o_row_cnt, o_col_cnt,
         o_in_frame, o_lof, o_crc_err_cnt}, 64'd0);
    rst_n = 1'b1;
  endtask

  // mode 1: every beat valid at row k/COLS col k%COLS; mode 2: every beat gated and at origin
  task automatic send_frame(input bit fas0, input bit gaps, input int spur, input bit crc,
                            input bit clr100, input int nbeats, input int mode);
    f_v0 = 0; f_if0 = 0; f_lof = 0; f_pos_bad = 0; f_gap_bad = 0;
    for (int k = 0; k < nbeats; k++) begin
      logic ce;
      ce = crc && (k >= 100) && (k < 110);
      if (gaps && (k % 2 == 0) && (k != 0)) begin
        drive(1'b0, 1'b0, 8'h00, ce, 1'b0);
        if (o_frame_data_valid !== 1'b0) f_gap_bad++;
        if (o_lof === 1'b1) f_lof++;
      end
      drive(1'b1, (fas0 && k == 0) || (k == spur), 8'(k), ce, clr100 && (k == 100));
      if (k == 0) begin
        f_v0  = int'(o_frame_data_valid);
        f_if0 = int'(o_in_frame);
      end
      if (o_lof === 1'b1) f_lof++;
      if (mode == 1) begin
        if (o_frame_data_valid !== 1'b1 || o_row_cnt !== 2'(k / COLS) ||
            o_col_cnt !== 11'(k % COLS) || o_frame_data !== 8'(k)) f_pos_bad++;
      end else if (mode == 2) begin
        if (o_frame_data_valid !== 1'b0 || o_row_cnt !== 2'd0 || o_col_cnt !== 11'd0) f_pos_bad++;
      end
      f_last_row = o_row_cnt;
      f_last_col = o_col_cnt;
    end
    i_crc_err = 1'b0;
    i_cnt_clr = 1'b0;
  endtask

  task automatic frame_checks(input string nm, input int ev0, input int eif0, input int elof);
    chk({nm, "_valid0"}, f_v0, ev0);
    chk({nm, "_inframe0"}, f_if0, eif0);
    chk({nm, "_lof"}, f_lof, elof);
    chk({nm, "_pos"}, f_pos_bad, 0);
    chk({nm, "_gap"}, f_gap_bad, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;

    //            v     f     d      vld   fas   row   col     inf   chkpos
    tbl[0] = '{1'b1, 1'b0, 8'hA1, 1'b0, 1'b0, 2'd0, 11'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 8'hB2, 1'b0, 1'b1, 2'd0, 11'd0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 2'd0, 11'd0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 2'd0, 11'd1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 2'd0, 11'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 2'd0, 11'd2, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 2'd0, 11'd3, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 8'h88, 1'b1, 1'b0, 2'd0, 11'd4, 1'b0, 1'b1};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].f, tbl[i].d, 1'b0, 1'b0);
      chk($sformatf("vec%0d_data", i), o_frame_data, tbl[i].d);
      chk($sformatf("vec%0d_valid", i), o_frame_data_valid, tbl[i].e_vld);
      chk($sformatf("vec%0d_fas", i), o_frame_data_fas, tbl[i].e_fas);
      chk($sformatf("vec%0d_inframe", i), o_in_frame, tbl[i].e_inf);
      chk($sformatf("vec%0d_lof", i), o_lof, 1'b0);
      if (tbl[i].chk_pos) chk($sformatf("vec%0d_pos", i), {o_row_cnt, o_col_cnt},
                              {tbl[i].e_row, tbl[i].e_col});
    end

    // Three clean frames
    do_reset();
    send_frame(1, 0, -1, 0, 0, FRAME_BEATS, 1);
    frame_checks("clean_a", 1, 0, 0);
    chk("clean_a_last_pos", {f_last_row, f_last_col}, {2'd3, 11'd1040});
    send_frame(1, 0, -1, 0, 0, FRAME_BEATS, 1);
    frame_checks("clean_b", 1, 1, 0);
    send_frame(1, 0, -1, 0, 0, FRAME_BEATS, 1);
    frame_checks("clean_c", 1, 1, 0);
    chk("clean_c_last_pos", {f_last_row, f_last_col}, {2'd3, 11'd1040});

    // Same three frames with valid low one cycle in three
    do_reset();
    send_frame(1, 1, -1, 0, 0, FRAME_BEATS, 1);
    frame_checks("gap_a", 1, 0, 0);
    send_frame(1, 1, -1, 0, 0, FRAME_BEATS, 1);
    frame_checks("gap_b", 1, 1, 0);
    send_frame(1, 1, -1, 0, 0, FRAME_BEATS, 1);
    frame_checks("gap_c", 1, 1, 0);
    chk("gap_c_last_pos", {f_last_row, f_last_col}, {2'd3, 11'd1040});

    // Two missing FAS then recovery, CRC pulse in each of these in-frame frames
    send_frame(0, 0, -1, 1, 0, FRAME_BEATS, 1);
    frame_checks("miss1", 1, 1, 0);
    send_frame(0, 0, -1, 1, 0, FRAME_BEATS, 1);
    frame_checks("miss2", 1, 1, 0);
    send_frame(1, 0, -1, 1, 0, FRAME_BEATS, 1);
    frame_checks("recover", 1, 1, 0);

    // Three missing FAS: loss of frame on the third
    send_frame(0, 0, -1, 1, 0, FRAME_BEATS, 1);
    frame_checks("loss1", 1, 1, 0);
    send_frame(0, 0, -1, 1, 0, FRAME_BEATS, 1);
    frame_checks("loss2", 1, 1, 0);
    chk("crc_cnt_in_lock", o_crc_err_cnt, 16'd5);
    send_frame(0, 0, -1, 1, 0, 200, 2);
    frame_checks("loss3", 0, 0, 1);
    send_frame(0, 0, -1, 1, 0, 200, 2);
    frame_checks("oof_idle", 0, 0, 0);
    chk("crc_cnt_after_oof", o_crc_err_cnt, 16'd5);

    // PRE_IF: spurious FAS at row 1 col 500 ignored, then missing FAS drops to OOF
    send_frame(1, 0, COLS + 500, 0, 0, FRAME_BEATS, 1);
    frame_checks("spur", 1, 0, 0);
    chk("spur_last_pos", {f_last_row, f_last_col}, {2'd3, 11'd1040});
    send_frame(0, 0, -1, 0, 0, 10, 2);
    frame_checks("spur_drop", 0, 0, 0);

    // Relock, then clear coincident with a CRC edge
    send_frame(1, 0, -1, 0, 0, FRAME_BEATS, 1);
    frame_checks("relock_a", 1, 0, 0);
    send_frame(1, 0, -1, 1, 1, 200, 1);
    frame_checks("relock_b", 1, 1, 0);
    chk("crc_cnt_clear_wins", o_crc_err_cnt, 16'd0);

    // Saturation at all-ones
    force dut.err_cnt = 16'hFFFE;
    #1;
    release dut.err_cnt;
    chk("crc_cnt_preset", o_crc_err_cnt, 16'hFFFE);
    for (int p = 0; p < 3; p++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk($sformatf("crc_sat_%0d", p), o_crc_err_cnt, 16'hFFFF);
    end

    // Asynchronous reset in the middle of a locked frame
    for (int b = 0; b < 5; b++) begin
      drive(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
      chk($sformatf("midframe_valid_%0d", b), {o_frame_data_valid, o_in_frame}, 2'b11);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {o_frame_data, o_frame_data_valid, o_frame_data_fas, o_row_cnt, o_col_cnt,
         o_in_frame, o_lof, o_crc_err_cnt}, 64'd0);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    chk("post_reset_gated", {o_frame_data_valid, o_in_frame}, 2'b00);
    drive(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
    chk("post_reset_fas", {o_frame_data_valid, o_in_frame, o_row_cnt, o_col_cnt},
        {1'b1, 1'b0, 2'd0, 11'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
